// File: rtl/al422_bam_sequencer_if.sv
// ---------------------------------------------------------------------------
// al422_bam_sequencer_if
// Start/busy handshake bundle between the BAM sequencer and its two worker
// stages (the row shift stage and the OE processor).
//
// Signals
//   shift_start       seq -> shift  one-clock load request for one row/plane
//   shift_addr_reset  seq -> shift  qualifies shift_start: rewind AL422 read pointer
//   shift_bit         seq -> shift  plane index being loaded (held between starts)
//   shift_busy        shift -> seq  shift stage busy, rises the cycle after start
//   oe_start          seq -> oe     one-clock display request for the latched plane
//   oe_duration       seq -> oe     on-time weight, 1 << displayed plane
//   oe_busy           oe -> seq     OE processor busy, rises the cycle after start
//
// Modports: master = sequencer side, slave = worker-stage side.
// ---------------------------------------------------------------------------
interface al422_bam_sequencer_if #(
  parameter int PWM_BITS  = 8,
  parameter int BIT_CNT_W = 3
);
  logic                 shift_start;
  logic                 shift_addr_reset;
  logic [BIT_CNT_W-1:0] shift_bit;
  logic                 shift_busy;
  logic                 oe_start;
  logic [PWM_BITS-1:0]  oe_duration;
  logic                 oe_busy;

  modport master (
    output shift_start,
    output shift_addr_reset,
    output shift_bit,
    output oe_start,
    output oe_duration,
    input  shift_busy,
    input  oe_busy
  );

  modport slave (
    input  shift_start,
    input  shift_addr_reset,
    input  shift_bit,
    input  oe_start,
    input  oe_duration,
    output shift_busy,
    output oe_busy
  );
endinterface

// File: rtl/al422_bam_sequencer.sv
// ---------------------------------------------------------------------------
// al422_bam_sequencer
// Autonomous row / bit-plane scheduler for the AL422 BAM LED driver. The shift
// stage loads plane N+1 while the OE processor displays plane N; between the
// two the panel is latched and the row address / OE weight are updated.
// Scan order: rows 0..2^ROW_BITS-1, planes 0..PWM_BITS-1 within each row.
//
// Ports
//   in_clk      system clock
//   in_nrst     asynchronous active-low reset
//   run         1 = keep scanning frames, 0 = stop at the next frame end
//   stage       handshake bundle (master side) to shift stage and OE processor
//   led_lat     panel latch, active high, LAT_WIDTH clocks
//   led_row     displayed row address
//   frame_done  one-clock pulse when the last plane of the last row finishes
//   busy        high whenever the sequencer is not idle
//
// Optional feature
//   AL422_BAM_ROW_BLANK_EN  when defined, a latch that changes led_row is
//                           followed by BLANK_CYCLES clocks with no starts
//                           before the plane is displayed.
// ---------------------------------------------------------------------------
module al422_bam_sequencer #(
  parameter int PWM_BITS     = 8,
  parameter int BIT_CNT_W    = 3,
  parameter int ROW_BITS     = 3,
  parameter int LAT_WIDTH    = 2,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                         in_clk,
  input  logic                         in_nrst,
  input  logic                         run,
  al422_bam_sequencer_if.master        stage,
  output logic                         led_lat,
  output logic [ROW_BITS-1:0]          led_row,
  output logic                         frame_done,
  output logic                         busy
);

`ifdef AL422_BAM_ROW_BLANK_EN
  localparam bit ROW_BLANK_EN = 1'b1;
`else
  localparam bit ROW_BLANK_EN = 1'b0;
`endif

  localparam bit BLANK_ACTIVE = ROW_BLANK_EN && (BLANK_CYCLES > 0);
  localparam int LAT_CNT_W    = (LAT_WIDTH > 1) ? $clog2(LAT_WIDTH) : 1;
  localparam int BLANK_CNT_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [BIT_CNT_W-1:0]   LAST_PLANE = BIT_CNT_W'(PWM_BITS - 1);
  localparam logic [ROW_BITS-1:0]    LAST_ROW   = {ROW_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]    ONE_DUR    = PWM_BITS'(1'b1);
  localparam logic [LAT_CNT_W-1:0]   LAT_LOAD   = LAT_CNT_W'(LAT_WIDTH - 1);
  localparam logic [BLANK_CNT_W-1:0] BLANK_LOAD = BLANK_CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PRELOAD   = 4'd1,
    ST_ARM_P     = 4'd2,
    ST_WAIT_P    = 4'd3,
    ST_LATCH     = 4'd4,
    ST_BLANK     = 4'd5,
    ST_DISPLAY   = 4'd6,
    ST_ARM       = 4'd7,
    ST_WAIT_BOTH = 4'd8
  } state_t;

  state_t                 state_r;
  logic [ROW_BITS-1:0]    row_ptr_r;
  logic [BIT_CNT_W-1:0]   plane_ptr_r;
  logic [LAT_CNT_W-1:0]   lat_cnt_r;
  logic [BLANK_CNT_W-1:0] blank_cnt_r;
  logic                   disp_final_r;
  logic                   shift_issued_r;
  logic                   blank_pending_r;

  logic                   shift_start_r;
  logic                   shift_addr_reset_r;
  logic [BIT_CNT_W-1:0]   shift_bit_r;
  logic                   oe_start_r;
  logic [PWM_BITS-1:0]    oe_duration_r;
  logic                   led_lat_r;
  logic [ROW_BITS-1:0]    led_row_r;
  logic                   frame_done_r;
  logic                   busy_r;

  logic [ROW_BITS-1:0]    next_row_s;
  logic [BIT_CNT_W-1:0]   next_plane_s;
  logic                   ptr_is_last_s;
  logic                   ptr_is_origin_s;
  logic                   row_change_s;
  logic                   disp_shift_s;
  logic                   go_latch_s;
  logic                   go_display_s;

  // Load-pointer successor and the latch/display transition decisions.
  always_comb begin
    next_row_s      = row_ptr_r;
    next_plane_s    = plane_ptr_r;
    ptr_is_last_s   = 1'b0;
    ptr_is_origin_s = (row_ptr_r == {ROW_BITS{1'b0}}) && (plane_ptr_r == {BIT_CNT_W{1'b0}});
    row_change_s    = (row_ptr_r != led_row_r);
    // The final plane of a frame only skips the look-ahead load when run is low.
    disp_shift_s    = !(disp_final_r && !run);
    go_latch_s      = 1'b0;
    go_display_s    = 1'b0;

    if (plane_ptr_r == LAST_PLANE) begin
      next_plane_s  = {BIT_CNT_W{1'b0}};
      next_row_s    = row_ptr_r + ROW_BITS'(1'b1);
      ptr_is_last_s = (row_ptr_r == LAST_ROW);
    end else begin
      next_plane_s  = plane_ptr_r + BIT_CNT_W'(1'b1);
      next_row_s    = row_ptr_r;
      ptr_is_last_s = 1'b0;
    end

    case (state_r)
      ST_WAIT_P: begin
        go_latch_s = !stage.shift_busy;
      end
      ST_WAIT_BOTH: begin
        go_latch_s = !stage.oe_busy && !stage.shift_busy && shift_issued_r;
      end
      ST_LATCH: begin
        go_display_s = (lat_cnt_r == {LAT_CNT_W{1'b0}}) && !blank_pending_r;
      end
      ST_BLANK: begin
        go_display_s = (blank_cnt_r == {BLANK_CNT_W{1'b0}});
      end
      default: begin
        go_latch_s   = 1'b0;
        go_display_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered outputs; pulse outputs default low each clock.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_r            <= ST_IDLE;
      row_ptr_r          <= {ROW_BITS{1'b0}};
      plane_ptr_r        <= {BIT_CNT_W{1'b0}};
      lat_cnt_r          <= {LAT_CNT_W{1'b0}};
      blank_cnt_r        <= {BLANK_CNT_W{1'b0}};
      disp_final_r       <= 1'b0;
      shift_issued_r     <= 1'b0;
      blank_pending_r    <= 1'b0;
      shift_start_r      <= 1'b0;
      shift_addr_reset_r <= 1'b0;
      shift_bit_r        <= {BIT_CNT_W{1'b0}};
      oe_start_r         <= 1'b0;
      oe_duration_r      <= {PWM_BITS{1'b0}};
      led_lat_r          <= 1'b0;
      led_row_r          <= {ROW_BITS{1'b0}};
      frame_done_r       <= 1'b0;
      busy_r             <= 1'b0;
    end else begin
      shift_start_r      <= 1'b0;
      shift_addr_reset_r <= 1'b0;
      oe_start_r         <= 1'b0;
      frame_done_r       <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (run) begin
            // Frame start: first load rewinds the AL422 read pointer.
            state_r            <= ST_PRELOAD;
            shift_start_r      <= 1'b1;
            shift_addr_reset_r <= 1'b1;
            shift_bit_r        <= {BIT_CNT_W{1'b0}};
            busy_r             <= 1'b1;
          end
        end
        ST_PRELOAD: begin
          state_r <= ST_ARM_P;
        end
        ST_ARM_P: begin
          state_r <= ST_WAIT_P;
        end
        ST_WAIT_P: begin
          state_r <= state_r;
        end
        ST_LATCH: begin
          if (lat_cnt_r != {LAT_CNT_W{1'b0}}) begin
            lat_cnt_r <= lat_cnt_r - LAT_CNT_W'(1'b1);
          end else begin
            led_lat_r <= 1'b0;
            if (blank_pending_r) begin
              state_r     <= ST_BLANK;
              blank_cnt_r <= BLANK_LOAD;
            end
          end
        end
        ST_BLANK: begin
          if (blank_cnt_r != {BLANK_CNT_W{1'b0}}) begin
            blank_cnt_r <= blank_cnt_r - BLANK_CNT_W'(1'b1);
          end
        end
        ST_DISPLAY: begin
          state_r <= ST_ARM;
        end
        ST_ARM: begin
          state_r <= ST_WAIT_BOTH;
        end
        ST_WAIT_BOTH: begin
          if (!stage.oe_busy && !stage.shift_busy) begin
            frame_done_r <= disp_final_r;
            if (!shift_issued_r) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase

      // Latch the plane just loaded, then step the load pointer past it.
      if (go_latch_s) begin
        state_r         <= ST_LATCH;
        led_lat_r       <= 1'b1;
        lat_cnt_r       <= LAT_LOAD;
        led_row_r       <= row_ptr_r;
        oe_duration_r   <= ONE_DUR << plane_ptr_r;
        disp_final_r    <= ptr_is_last_s;
        blank_pending_r <= BLANK_ACTIVE && row_change_s;
        row_ptr_r       <= next_row_s;
        plane_ptr_r     <= next_plane_s;
      end

      // Display the latched plane and overlap the next load with it.
      if (go_display_s) begin
        state_r            <= ST_DISPLAY;
        oe_start_r         <= 1'b1;
        shift_start_r      <= disp_shift_s;
        shift_addr_reset_r <= disp_shift_s && ptr_is_origin_s;
        shift_issued_r     <= disp_shift_s;
        if (disp_shift_s) begin
          shift_bit_r <= plane_ptr_r;
        end
      end
    end
  end

  assign stage.shift_start      = shift_start_r;
  assign stage.shift_addr_reset = shift_addr_reset_r;
  assign stage.shift_bit        = shift_bit_r;
  assign stage.oe_start         = oe_start_r;
  assign stage.oe_duration      = oe_duration_r;
  assign led_lat                = led_lat_r;
  assign led_row                = led_row_r;
  assign frame_done             = frame_done_r;
  assign busy                   = busy_r;

endmodule

// File: tb/tb_al422_bam_sequencer.sv
// ---------------------------------------------------------------------------
// tb_al422_bam_sequencer
// Self-checking bench: worker stages are modelled as busy timers of random
// length; a scan-order model (plain counters: n-th load / n-th latch map to
// row = (n / PWM_BITS) % ROWS, plane = n % PWM_BITS) predicts every latch,
// every load request, row-change gaps and frame_done pulses.
// ---------------------------------------------------------------------------
module tb_al422_bam_sequencer;
  localparam int PWM_BITS     = 2;
  localparam int BIT_CNT_W    = 1;
  localparam int ROW_BITS     = 1;
  localparam int LAT_WIDTH    = 1;
  localparam int BLANK_CYCLES = 4;
  localparam int ROWS         = 1 << ROW_BITS;
  localparam int FRAME        = ROWS * PWM_BITS;
`ifdef AL422_BAM_ROW_BLANK_EN
  localparam int ROW_GAP = BLANK_CYCLES;
`else
  localparam int ROW_GAP = 0;
`endif

  logic                in_clk = 1'b0;
  logic                in_nrst;
  logic                run;
  logic                led_lat;
  logic [ROW_BITS-1:0] led_row;
  logic                frame_done;
  logic                busy;

  al422_bam_sequencer_if #(.PWM_BITS(PWM_BITS), .BIT_CNT_W(BIT_CNT_W)) bus ();

  al422_bam_sequencer #(
    .PWM_BITS(PWM_BITS), .BIT_CNT_W(BIT_CNT_W), .ROW_BITS(ROW_BITS),
    .LAT_WIDTH(LAT_WIDTH), .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .in_clk(in_clk), .in_nrst(in_nrst), .run(run), .stage(bus),
    .led_lat(led_lat), .led_row(led_row), .frame_done(frame_done), .busy(busy)
  );

  always #5 in_clk = ~in_clk;

  // Stage models: busy for a random number of clocks after each start.
  int shift_lo = 5, shift_hi = 5, oe_lo = 3, oe_hi = 3;
  int shift_tmr, oe_tmr;
  always @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) shift_tmr <= 0;
    else if (bus.shift_start) shift_tmr <= int'($urandom_range(shift_hi, shift_lo));
    else if (shift_tmr != 0) shift_tmr <= shift_tmr - 1;
  end
  always @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) oe_tmr <= 0;
    else if (bus.oe_start) oe_tmr <= int'($urandom_range(oe_hi, oe_lo));
    else if (oe_tmr != 0) oe_tmr <= oe_tmr - 1;
  end
  assign bus.shift_busy = (shift_tmr != 0);
  assign bus.oe_busy    = (oe_tmr != 0);

  int chk_cnt = 0, pass_cnt = 0;
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Scan-order reference model, evaluated on every falling edge.
  int d_cnt, k_cnt, oe_seen, fd_cnt, last_row_m, gap_cnt;
  bit disp_final_m, row_chg_m, prev_lat;
  always @(negedge in_clk) begin
    if (!in_nrst) begin
      d_cnt = 0; k_cnt = 0; oe_seen = 0; fd_cnt = 0; last_row_m = 0; gap_cnt = 0;
      disp_final_m = 0; row_chg_m = 0; prev_lat = 0;
    end else begin
      if (frame_done) begin
        fd_cnt++;
        check_val("frame_done_pos", 32'((d_cnt % FRAME) == 0 && d_cnt != 0), 32'd1);
      end
      if (led_lat && !prev_lat) begin
        int er, ep;
        er = (d_cnt / PWM_BITS) % ROWS;
        ep = d_cnt % PWM_BITS;
        check_val("latch_row", 32'(led_row), 32'(er));
        check_val("latch_dur", 32'(bus.oe_duration), 32'd1 << ep);
        row_chg_m    = (er != last_row_m);
        last_row_m   = er;
        disp_final_m = ((d_cnt % FRAME) == FRAME - 1);
        d_cnt++;
      end
      if (led_lat) begin
        check_val("lat_oe_idle", 32'(bus.oe_busy), 32'd0);
        check_val("lat_shift_idle", 32'(bus.shift_busy), 32'd0);
        gap_cnt = 0;
      end else if (bus.oe_start) begin
        oe_seen++;
        check_val("oe_after_latch", 32'(oe_seen), 32'(d_cnt));
        check_val("row_gap", 32'(gap_cnt), row_chg_m ? 32'(ROW_GAP) : 32'd0);
        check_val("disp_shift", 32'(bus.shift_start), 32'(!(disp_final_m && !run)));
      end else begin
        gap_cnt++;
      end
      if (bus.shift_start) begin
        int lr, lp;
        lp = k_cnt % PWM_BITS;
        lr = (k_cnt / PWM_BITS) % ROWS;
        check_val("shift_bit", 32'(bus.shift_bit), 32'(lp));
        check_val("shift_addr_reset", 32'(bus.shift_addr_reset), 32'(lp == 0 && lr == 0));
        k_cnt++;
      end else if (bus.shift_addr_reset) begin
        check_val("addr_rst_qual", 32'(bus.shift_start), 32'd1);
      end
      prev_lat = led_lat;
    end
  end

  task automatic tick();
    @(negedge in_clk);
    #1;
  endtask

  // Wait (bounded) until the DUT is in DISPLAY for the latch with index target-1.
  task automatic wait_display(input int target);
    bit found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick();
      if (bus.oe_start && d_cnt == target) found = 1;
    end
    check_val("reach_display", 32'(found), 32'd1);
  endtask

  // Drop run during the given display, then check the frame finishes cleanly.
  task automatic stop_at(input int target);
    int k_hold;
    wait_display(target);
    run = 1'b0;
    for (int i = 0; i < 4000 && busy; i++) tick();
    check_val("stop_idle", 32'(busy), 32'd0);
    check_val("stop_whole_frame", 32'(d_cnt % FRAME), 32'd0);
    check_val("stop_no_extra_load", 32'(k_cnt), 32'(d_cnt));
    check_val("stop_frame_cnt", 32'(fd_cnt), 32'(d_cnt / FRAME));
    k_hold = k_cnt;
    for (int i = 0; i < 10; i++) tick();
    check_val("stop_stays_idle", 32'(k_cnt + oe_seen), 32'(k_hold + d_cnt));
    check_val("stop_lat_low", 32'(led_lat), 32'd0);
  endtask

  task automatic run_frames(input int frames, input int slo, input int shi, input int olo, input int ohi);
    shift_lo = slo; shift_hi = shi; oe_lo = olo; oe_hi = ohi;
    run = 1'b1;
    // Stop request lands in row 1 / plane 0 display of the last frame.
    stop_at(d_cnt + (frames - 1) * FRAME + PWM_BITS + 1);
  endtask

  initial begin
    bit seen;
    in_nrst = 1'b0;
    run     = 1'b0;
    repeat (3) tick();
    in_nrst = 1'b1;

    // Reset / idle with run low.
    repeat (20) tick();
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_outs", 32'({led_lat, led_row, frame_done, bus.oe_duration,
                                bus.shift_bit, bus.shift_addr_reset}), 32'd0);
    check_val("idle_no_starts", 32'(k_cnt + oe_seen), 32'd0);

    // Nominal frames, handshake stress both ways, then random lengths.
    run_frames(3, 5, 5, 3, 3);
    run_frames(2, 2, 2, 40, 40);
    run_frames(2, 40, 40, 2, 2);
    run_frames(3, 1, 12, 1, 12);

    // Asynchronous reset in the middle of a DISPLAY.
    shift_lo = 5; shift_hi = 5; oe_lo = 3; oe_hi = 3;
    run = 1'b1;
    wait_display(d_cnt + 3);
    #2 in_nrst = 1'b0;
    #1;
    check_val("arst_oe_start", 32'(bus.oe_start), 32'd0);
    check_val("arst_outs", 32'({led_lat, led_row, frame_done, busy, bus.oe_duration,
                                bus.shift_start, bus.shift_bit, bus.shift_addr_reset}), 32'd0);
    tick();
    tick();
    in_nrst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.shift_start) seen = 1;
    end
    check_val("restart_preload", 32'(seen), 32'd1);
    check_val("restart_addr_reset", 32'(bus.shift_addr_reset), 32'd1);
    check_val("restart_busy", 32'(busy), 32'd1);
    stop_at(PWM_BITS + 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
